// File: rtl/ccp_tag_bank_sched.sv
// Per-bank lookup scheduler for the CCP tag pipe: decodes requester addresses,
// arbitrates round-robin per tag bank and holds off sets still in flight.
module ccp_tag_bank_sched #(
  parameter int N_REQ               = 4,
  parameter int N_TAG_BANKS         = 2,
  parameter int BNK_W               = $clog2(N_TAG_BANKS),
  parameter int N_SETS              = 1024,
  parameter int SET_PER_BANK_W      = $clog2(N_SETS / N_TAG_BANKS),
  parameter int ADDRESS_W           = 32,
  parameter int CACHE_LINE_OFFSET_W = 6,
  parameter int BANK_SEL_LSB        = 0,
  parameter int TAG_W               = ADDRESS_W - (CACHE_LINE_OFFSET_W + SET_PER_BANK_W + BNK_W),
  parameter int PIPE_DEPTH          = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [N_REQ*ADDRESS_W-1:0]            req_addr,
  output logic [N_REQ-1:0]                      req_ready,
  input  logic [N_TAG_BANKS-1:0]                bank_stall,
  output logic [N_TAG_BANKS-1:0]                bank_vld,
  output logic [N_TAG_BANKS*SET_PER_BANK_W-1:0] bank_set,
  output logic [N_TAG_BANKS*TAG_W-1:0]          bank_tag,
  output logic [N_TAG_BANKS*$clog2(N_REQ)-1:0]  bank_req_id
);

  localparam int ID_W    = $clog2(N_REQ);
  localparam int IDX_W   = SET_PER_BANK_W + BNK_W;
  localparam int TAG_LSB = CACHE_LINE_OFFSET_W + IDX_W;

  // Set number is the index with the bank-select field squeezed out.
  function automatic logic [SET_PER_BANK_W-1:0] idx_to_set(input logic [IDX_W-1:0] idx);
    logic [SET_PER_BANK_W-1:0] s;
    s = '0;
    for (int j = 0; j < SET_PER_BANK_W; j++) begin
      s[j] = idx[(j < BANK_SEL_LSB) ? j : j + BNK_W];
    end
    return s;
  endfunction

  logic [BNK_W-1:0]          dec_bank [N_REQ];
  logic [SET_PER_BANK_W-1:0] dec_set  [N_REQ];
  logic [TAG_W-1:0]          dec_tag  [N_REQ];

  logic                      pipe_vld [N_TAG_BANKS][PIPE_DEPTH];
  logic [SET_PER_BANK_W-1:0] pipe_set [N_TAG_BANKS][PIPE_DEPTH];
  logic [TAG_W-1:0]          pipe_tag [N_TAG_BANKS][PIPE_DEPTH];
  logic [ID_W-1:0]           pipe_id  [N_TAG_BANKS][PIPE_DEPTH];
  logic [ID_W-1:0]           rr_ptr   [N_TAG_BANKS];

  logic [N_REQ-1:0]          conflict [N_TAG_BANKS];
  logic [N_REQ-1:0]          elig     [N_TAG_BANKS];
  logic [N_REQ-1:0]          gnt      [N_TAG_BANKS];
  logic [N_TAG_BANKS-1:0]    gnt_any;
  logic [ID_W-1:0]           gnt_id   [N_TAG_BANKS];
  logic                      unused_offset_bits;

  for (genvar i = 0; i < N_REQ; i++) begin : g_dec
    logic [IDX_W-1:0] idx;
    assign idx         = req_addr[i*ADDRESS_W + CACHE_LINE_OFFSET_W +: IDX_W];
    assign dec_bank[i] = idx[BANK_SEL_LSB +: BNK_W];
    assign dec_set[i]  = idx_to_set(idx);
    assign dec_tag[i]  = req_addr[i*ADDRESS_W + TAG_LSB +: TAG_W];
  end

  always_comb begin
    unused_offset_bits = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      unused_offset_bits = unused_offset_bits ^ (^req_addr[i*ADDRESS_W +: CACHE_LINE_OFFSET_W]);
    end
  end

  always_comb begin
    for (int b = 0; b < N_TAG_BANKS; b++) begin
      conflict[b] = '0;
      for (int i = 0; i < N_REQ; i++) begin
        for (int s = 0; s < PIPE_DEPTH; s++) begin
          if (pipe_vld[b][s] && (pipe_set[b][s] == dec_set[i])) conflict[b][i] = 1'b1;
        end
      end
    end
  end

  // Scan requesters starting at rr_ptr; blocked requesters are simply skipped.
  always_comb begin
    for (int b = 0; b < N_TAG_BANKS; b++) begin
      gnt_any[b] = 1'b0;
      gnt_id[b]  = '0;
      gnt[b]     = '0;
      for (int i = 0; i < N_REQ; i++) begin
        elig[b][i] = req_valid[i] && (dec_bank[i] == BNK_W'(b)) &&
                     !bank_stall[b] && !conflict[b][i];
      end
      for (int k = 0; k < N_REQ; k++) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!gnt_any[b] && elig[b][i] && (i == (int'(rr_ptr[b]) + k) % N_REQ)) begin
            gnt_any[b] = 1'b1;
            gnt_id[b]  = ID_W'(i);
            gnt[b][i]  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset) begin
      for (int b = 0; b < N_TAG_BANKS; b++) req_ready = req_ready | gnt[b];
    end
  end

  // Tracker: stage 0 is the issue slot, older stages only feed the conflict check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < N_TAG_BANKS; b++) begin
        rr_ptr[b] <= '0;
        for (int s = 0; s < PIPE_DEPTH; s++) begin
          pipe_vld[b][s] <= 1'b0;
          pipe_set[b][s] <= '0;
          pipe_tag[b][s] <= '0;
          pipe_id[b][s]  <= '0;
        end
      end
    end else begin
      for (int b = 0; b < N_TAG_BANKS; b++) begin
        for (int s = 1; s < PIPE_DEPTH; s++) begin
          pipe_vld[b][s] <= pipe_vld[b][s-1];
          pipe_set[b][s] <= pipe_set[b][s-1];
          pipe_tag[b][s] <= pipe_tag[b][s-1];
          pipe_id[b][s]  <= pipe_id[b][s-1];
        end
        pipe_vld[b][0] <= gnt_any[b];
        if (gnt_any[b]) begin
          pipe_set[b][0] <= dec_set[gnt_id[b]];
          pipe_tag[b][0] <= dec_tag[gnt_id[b]];
          pipe_id[b][0]  <= gnt_id[b];
          rr_ptr[b]      <= ID_W'((int'(gnt_id[b]) + 1) % N_REQ);
        end
      end
    end
  end

  for (genvar b = 0; b < N_TAG_BANKS; b++) begin : g_out
    assign bank_vld[b]                                   = pipe_vld[b][0];
    assign bank_set[b*SET_PER_BANK_W +: SET_PER_BANK_W] = pipe_set[b][0];
    assign bank_tag[b*TAG_W +: TAG_W]                   = pipe_tag[b][0];
    assign bank_req_id[b*ID_W +: ID_W]                  = pipe_id[b][0];
  end

endmodule

// File: tb/tb_ccp_tag_bank_sched.sv
// Directed bench for ccp_tag_bank_sched at default parameters (4 requesters,
// 2 banks, 9-bit set, 16-bit tag, 3-deep tracker).
module tb_ccp_tag_bank_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [3:0]   req_ready;
  logic [1:0]   bank_stall;
  logic [1:0]   bank_vld;
  logic [17:0]  bank_set;
  logic [31:0]  bank_tag;
  logic [3:0]   bank_req_id;

  int vectors = 0;
  int miscompares = 0;

  ccp_tag_bank_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .bank_stall(bank_stall), .bank_vld(bank_vld),
    .bank_set(bank_set), .bank_tag(bank_tag), .bank_req_id(bank_req_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input int b, input logic [8:0] s,
                            input logic [15:0] t, input logic [1:0] id);
    chk({tag, "_set"}, bank_set[b*9 +: 9], s);
    chk({tag, "_tag"}, bank_tag[b*16 +: 16], t);
    chk({tag, "_id"},  bank_req_id[b*2 +: 2], id);
  endtask

  // addr = {tag, set, bank, line offset}
  function automatic logic [31:0] mk(input logic [15:0] t, input logic [8:0] s, input logic b);
    return {t, s, b, 6'b0};
  endfunction

  task automatic put(input int i, input logic [31:0] a);
    req_addr[i*32 +: 32] = a;
    req_valid[i] = 1'b1;
  endtask

  task automatic drop(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_addr = '0; bank_stall = '0;
    #1 reset = 1'b1;
    put(0, mk(16'h1, 9'h1, 1'b0));
    settle();
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_vld", bank_vld, 2'b00);
    chk("rst_set", bank_set, 18'h0);
    chk("rst_tag", bank_tag, 32'h0);
    chk("rst_id", bank_req_id, 4'h0);
    tick(); tick();
    chk("rst_hold_vld", bank_vld, 2'b00);
    req_valid = '0; reset = 1'b0;
    settle();
    chk("idle_ready", req_ready, 4'b0000);

    // single request to bank 1
    put(0, 32'h0000_0040);
    settle();
    chk("single_ready", req_ready, 4'b0001);
    tick(); drop(0);
    chk("single_vld", bank_vld, 2'b10);
    chk_fields("single", 1, 9'h0, 16'h0, 2'd0);
    tick();
    chk("single_once", bank_vld, 2'b00);

    // round-robin within bank 0
    put(0, mk(16'h11, 9'h1, 1'b0)); put(1, mk(16'h22, 9'h2, 1'b0)); put(2, mk(16'h33, 9'h3, 1'b0));
    settle();
    chk("rr0_ready", req_ready, 4'b0001);
    tick(); drop(0);
    chk("rr0_vld", bank_vld, 2'b01);
    chk_fields("rr0", 0, 9'h1, 16'h11, 2'd0);
    settle();
    chk("rr1_ready", req_ready, 4'b0010);
    tick(); drop(1);
    chk("rr1_vld", bank_vld, 2'b01);
    chk_fields("rr1", 0, 9'h2, 16'h22, 2'd1);
    settle();
    chk("rr2_ready", req_ready, 4'b0100);
    tick(); drop(2);
    chk("rr2_vld", bank_vld, 2'b01);
    chk_fields("rr2", 0, 9'h3, 16'h33, 2'd2);
    put(3, mk(16'h44, 9'h4, 1'b0)); put(0, mk(16'h55, 9'h5, 1'b0));
    settle();
    chk("rr3_ready", req_ready, 4'b1000);
    tick(); drop(3);
    chk_fields("rr3", 0, 9'h4, 16'h44, 2'd3);
    settle();
    chk("rr_wrap_ready", req_ready, 4'b0001);
    tick(); drop(0);
    chk("rr_wrap_vld", bank_vld, 2'b01);
    chk_fields("rr_wrap", 0, 9'h5, 16'h55, 2'd0);
    tick();
    chk("rr_done_vld", bank_vld, 2'b00);
    tick(); tick();

    // parallel banks
    put(0, mk(16'h1234, 9'h55, 1'b0)); put(1, mk(16'h4321, 9'h55, 1'b1));
    settle();
    chk("par_ready", req_ready, 4'b0011);
    tick(); drop(0); drop(1);
    chk("par_vld", bank_vld, 2'b11);
    chk_fields("par_b0", 0, 9'h55, 16'h1234, 2'd0);
    chk_fields("par_b1", 1, 9'h55, 16'h4321, 2'd1);
    tick();
    chk("par_done_vld", bank_vld, 2'b00);

    // stall bank 0 for three cycles, bank 1 keeps flowing
    bank_stall = 2'b01;
    put(0, mk(16'h77, 9'h20, 1'b0)); put(1, mk(16'h88, 9'h21, 1'b1));
    settle();
    chk("stall0_ready", req_ready, 4'b0010);
    tick(); drop(1);
    chk("stall0_vld", bank_vld, 2'b10);
    chk_fields("stall0", 1, 9'h21, 16'h88, 2'd1);
    settle();
    chk("stall1_ready", req_ready, 4'b0000);
    tick();
    chk("stall1_vld", bank_vld, 2'b00);
    put(2, mk(16'h99, 9'h22, 1'b1));
    settle();
    chk("stall2_ready", req_ready, 4'b0100);
    tick(); drop(2);
    chk("stall2_vld", bank_vld, 2'b10);
    chk_fields("stall2", 1, 9'h22, 16'h99, 2'd2);
    bank_stall = 2'b00;
    settle();
    chk("unstall_ready", req_ready, 4'b0001);
    tick(); drop(0);
    chk("unstall_vld", bank_vld, 2'b01);
    chk_fields("unstall", 0, 9'h20, 16'h77, 2'd0);
    tick();
    chk("unstall_done_vld", bank_vld, 2'b00);

    // reset with three entries in flight
    put(0, mk(16'hA0, 9'h30, 1'b0));
    settle();
    chk("fill0_ready", req_ready, 4'b0001);
    tick(); drop(0);
    put(1, mk(16'hA1, 9'h31, 1'b0));
    settle();
    chk("fill1_ready", req_ready, 4'b0010);
    tick(); drop(1);
    put(2, mk(16'hA2, 9'h32, 1'b0));
    settle();
    chk("fill2_ready", req_ready, 4'b0100);
    tick(); drop(2);
    chk("fill2_vld", bank_vld, 2'b01);
    chk_fields("fill2", 0, 9'h32, 16'hA2, 2'd2);
    put(3, mk(16'hA3, 9'h32, 1'b0));
    settle();
    chk("pre_rst_conflict_ready", req_ready, 4'b0000);
    reset = 1'b1;
    settle();
    chk("async_rst_vld", bank_vld, 2'b00);
    chk("async_rst_ready", req_ready, 4'b0000);
    chk("async_rst_set", bank_set, 18'h0);
    tick();
    reset = 1'b0;
    settle();
    chk("post_rst_ready", req_ready, 4'b1000);
    tick(); drop(3);
    chk("post_rst_vld", bank_vld, 2'b01);
    chk_fields("post_rst", 0, 9'h32, 16'hA3, 2'd3);
    tick();
    chk("post_rst_stale1", bank_vld, 2'b00);
    tick();
    chk("post_rst_stale2", bank_vld, 2'b00);

    // same-set conflict: req 1 waits for req 0 to clear the tracker
    put(0, mk(16'h000A, 9'h7, 1'b0)); put(1, mk(16'h000B, 9'h7, 1'b0));
    settle();
    chk("conf_t0_ready", req_ready, 4'b0001);
    tick(); drop(0);
    chk("conf_t1_vld", bank_vld, 2'b01);
    chk_fields("conf_t1", 0, 9'h7, 16'h000A, 2'd0);
    put(2, mk(16'h000C, 9'h8, 1'b0));
    settle();
    chk("conf_t1_ready", req_ready, 4'b0100);
    tick(); drop(2);
    chk_fields("conf_bypass", 0, 9'h8, 16'h000C, 2'd2);
    settle();
    chk("conf_t2_ready", req_ready, 4'b0000);
    tick();
    chk("conf_t3_vld", bank_vld, 2'b00);
    settle();
    chk("conf_t3_ready", req_ready, 4'b0000);
    tick();
    chk("conf_t4_vld", bank_vld, 2'b00);
    settle();
    chk("conf_t4_ready", req_ready, 4'b0010);
    tick(); drop(1);
    chk("conf_t5_vld", bank_vld, 2'b01);
    chk_fields("conf_t5", 0, 9'h7, 16'h000B, 2'd1);
    tick();
    chk("conf_done_vld", bank_vld, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ccp_tag_bank_sched.md
# ccp_tag_bank_sched

Per-bank scheduler for the CCP tag pipe: accepts lookup requests from N_REQ requesters, decodes each address into tag bank, set and tag, and issues at most one lookup per tag bank per cycle. Round-robin arbitration runs independently for each bank. Same-set requests are held off while an earlier lookup to that set is still in the bank pipe. Sits between the native-side request queues and the tag-bank SRAM pipelines.

## Interface
- N_REQ, 4, number of requesters
- N_TAG_BANKS, 2, tag banks; power of 2, ≥2
- BNK_W, $clog2(N_TAG_BANKS), bank select width
- N_SETS, 1024, total sets across all banks
- SET_PER_BANK_W, $clog2(N_SETS/N_TAG_BANKS), set width per bank
- ADDRESS_W, 32, request address width
- CACHE_LINE_OFFSET_W, 6, line offset width
- BANK_SEL_LSB, 0, LSB of bank select bits within the index field
- TAG_W, ADDRESS_W-(CACHE_LINE_OFFSET_W+SET_PER_BANK_W+BNK_W), tag width
- PIPE_DEPTH, 3, tag-pipe occupancy in cycles for conflict tracking; ≥1
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request valid, one bit per requester
- req_addr  in  N_REQ*ADDRESS_W  request addresses; requester i at [i*ADDRESS_W +: ADDRESS_W]
- req_ready  out  N_REQ  request accepted this cycle
- bank_stall  in  N_TAG_BANKS  bank b takes no new issue this cycle
- bank_vld  out  N_TAG_BANKS  lookup issued to bank b
- bank_set  out  N_TAG_BANKS*SET_PER_BANK_W  set per bank
- bank_tag  out  N_TAG_BANKS*TAG_W  tag per bank
- bank_req_id  out  N_TAG_BANKS*$clog2(N_REQ)  winning requester per bank

## Operation
- Decode: index = addr[CACHE_LINE_OFFSET_W +: SET_PER_BANK_W+BNK_W].
  - bank = index[BANK_SEL_LSB +: BNK_W].
  - set = the remaining index bits, order preserved, low to high.
  - tag = addr[ADDRESS_W-1 : CACHE_LINE_OFFSET_W+SET_PER_BANK_W+BNK_W].
- Per bank b, the in-flight tracker is a shift register of PIPE_DEPTH stages. Each stage holds {valid, set, tag, req_id}.
  - Stage 0 drives bank_vld/bank_set/bank_tag/bank_req_id.
  - All stages shift every cycle. The last stage drops out.
- Requester i is eligible for bank b when all of these hold:
  - req_valid[i] is high;
  - its decoded bank == b;
  - bank_stall[b] is low;
  - no valid stage of bank b holds the same set.
- Arbitration per bank: among eligible requesters, grant the first at or after rr_ptr[b], wrapping modulo N_REQ.
  - On grant, rr_ptr[b] ← winner+1 mod N_REQ.
  - With no grant, rr_ptr[b] is unchanged.
- req_ready[i] = granted by its bank. It is combinational from req_valid, req_addr and registered state. It is forced 0 while reset is high.
- On accept, the decoded {set, tag, i} loads into stage 0 of the bank with valid=1. Otherwise stage 0 loads valid=0.
- Each requester maps to exactly one bank, so one requester can never be granted twice in a cycle. Different banks grant in parallel.
- Conflict-blocked or stalled requesters do not block other requesters of the same bank.
- Reset: all stages invalid and all rr_ptr = 0.
  - Reset values: bank_vld=0, bank_set=0, bank_tag=0, bank_req_id=0, req_ready=0.
  - Reset mid-operation discards every in-flight entry. No lookup is issued after reset deasserts unless a fresh request arrives.

## Timing
- Accept at cycle T (req_valid && req_ready) → bank_vld high at T+1, for exactly one cycle per accept.
- Back-to-back different-set requests to one bank can be accepted every cycle.
- The same set in the same bank is re-accepted no earlier than T+PIPE_DEPTH+1. With PIPE_DEPTH=3, the minimum spacing is 4 cycles.
- bank_stall[b] high at cycle T: no accept for bank b at T. Entries already in flight still emerge and shift.
- Requesters hold req_valid/req_addr stable until accepted. Dropping valid before acceptance is legal and leaves no state behind.
- Two requesters with the same bank and set in the same cycle: only the round-robin winner is accepted. The other becomes eligible after the winner clears the tracker.

## Test plan
- Single request: req 0, addr 0x0000_0040 (default params), accepted at T.
  - Required: bank_vld[1] at T+1, set 0, tag 0, id 0.
- Round-robin, same bank: req 0,1,2 all valid, different sets, all bank 0.
  - Required: grants in order 0,1,2 on consecutive cycles; rr_ptr[0]=3 afterwards.
  - Then req 3 and req 0 valid: req 3 wins first.
- Set conflict: req 0 and req 1 with the same bank and set in the same cycle.
  - Required: req 0 accepted at T, req 1 accepted at T+4 (PIPE_DEPTH=3). bank_vld pulses at T+1 and T+5.
- Parallel banks: req 0 to bank 0 and req 1 to bank 1 in the same cycle.
  - Required: both req_ready high; bank_vld=2'b11 next cycle with correct ids.
- Stall: bank_stall[0] high for cycles T..T+2 with req 0 pending to bank 0.
  - Required: no req_ready during the stall, accept at T+3, bank_vld[0] at T+4.
  - Required: requests to bank 1 are unaffected throughout.
- Reset mid-operation: assert reset with 3 entries in flight.
  - Required: bank_vld=0 immediately (asynchronous) and no stale pulses after deassert.
  - Required: a same-set request is accepted on the first cycle after reset.
